// File: rtl/program_sequencer.sv
// Program counter and instruction memory ahead of the CPU control unit.
// After reset it can stream a bootstrap image into memory; the CPU is held idle until RUN.
//
// state | meaning
// CHECK | one cycle after reset; boot_en picks LOAD or RUN
// LOAD  | accept image bytes over valid/ready, one per cycle
// DONE  | one cycle; clear PC before releasing the CPU
// RUN   | PC follows pc_load / pc_inc from the control unit
module program_sequencer #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              boot_en,
    input  logic              boot_valid,
    input  logic [DATA_W-1:0] boot_data,
    input  logic              boot_last,
    output logic              boot_ready,
    input  logic              pc_inc,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_next,
    output logic [DATA_W-1:0] flash_data,
    output logic [ADDR_W-1:0] pc,
    output logic              bootstrapping,
    output logic              cpu_hold,
    output logic [ADDR_W:0]   load_count
);

    typedef enum logic [1:0] {
        S_CHECK = 2'd0,
        S_LOAD  = 2'd1,
        S_DONE  = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [ADDR_W:0]   load_count_q, load_count_d;
    logic              mem_we;

    // Memory is deliberately not reset so an image survives a warm reset.
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q      <= S_CHECK;
            pc_q         <= '0;
            waddr_q      <= '0;
            load_count_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            waddr_q      <= waddr_d;
            load_count_q <= load_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[waddr_q] <= boot_data;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        waddr_d      = waddr_q;
        load_count_d = load_count_q;
        mem_we       = 1'b0;
        case (state_q)
            S_CHECK: begin
                pc_d    = '0;
                waddr_d = '0;
                if (boot_en) begin
                    state_d      = S_LOAD;
                    load_count_d = '0;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_LOAD: begin
                if (boot_valid) begin
                    mem_we       = 1'b1;
                    waddr_d      = waddr_q + 1'b1;
                    load_count_d = load_count_q + 1'b1;
                    // Top address ends the load so waddr never wraps onto the image start.
                    if (boot_last || (waddr_q == {ADDR_W{1'b1}})) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                pc_d    = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (pc_load) begin
                    pc_d = pc_next;
                end else if (pc_inc) begin
                    pc_d = pc_q + 1'b1;
                end
            end
            default: state_d = S_CHECK;
        endcase
    end

    assign boot_ready    = (state_q == S_LOAD);
    assign bootstrapping = (state_q != S_RUN);
    assign cpu_hold      = (state_q != S_RUN);
    assign pc            = pc_q;
    assign load_count    = load_count_q;
    assign flash_data    = mem_q[pc_q];

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: reset paths, bootstrap load, fetch, jump/wrap,
// overflow load and reset in the middle of a load.
module tb_program_sequencer;

    logic        clk = 1'b0;
    logic        arst;
    logic        boot_en, boot_valid, boot_last;
    logic [7:0]  boot_data;
    logic        boot_ready;
    logic        pc_inc, pc_load;
    logic [11:0] pc_next;
    logic [7:0]  flash_data;
    logic [11:0] pc;
    logic        bootstrapping, cpu_hold;
    logic [12:0] load_count;

    int tests_run = 0;
    int tests_failed = 0;

    program_sequencer dut (
        .clk          (clk),
        .arst         (arst),
        .boot_en      (boot_en),
        .boot_valid   (boot_valid),
        .boot_data    (boot_data),
        .boot_last    (boot_last),
        .boot_ready   (boot_ready),
        .pc_inc       (pc_inc),
        .pc_load      (pc_load),
        .pc_next      (pc_next),
        .flash_data   (flash_data),
        .pc           (pc),
        .bootstrapping(bootstrapping),
        .cpu_hold     (cpu_hold),
        .load_count   (load_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; inputs are driven and outputs sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        arst = 1'b1;
        #2;
        arst = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        boot_valid = 1'b1;
        boot_data  = d;
        boot_last  = last;
        step();
        boot_valid = 1'b0;
        boot_last  = 1'b0;
    endtask

    initial begin
        int accepted;
        int first_drop;

        arst = 1'b1;
        boot_en = 1'b0; boot_valid = 1'b0; boot_last = 1'b0; boot_data = 8'h00;
        pc_inc = 1'b0; pc_load = 1'b0; pc_next = 12'h000;
        #2;
        chk("rst_cpu_hold", cpu_hold, 1);
        chk("rst_bootstrapping", bootstrapping, 1);
        chk("rst_boot_ready", boot_ready, 0);
        chk("rst_pc", pc, 0);
        chk("rst_load_count", load_count, 0);

        // Bootstrap disabled: one CHECK cycle then RUN.
        step();
        arst = 1'b0;
        chk("nb_check_hold", cpu_hold, 1);
        chk("nb_check_ready", boot_ready, 0);
        step();
        chk("nb_run_hold", cpu_hold, 0);
        chk("nb_run_bootstrapping", bootstrapping, 0);
        chk("nb_run_ready", boot_ready, 0);
        chk("nb_run_pc", pc, 0);
        chk("nb_run_load_count", load_count, 0);

        // Three-byte bootstrap with an idle cycle between bytes 1 and 2.
        pulse_reset();
        boot_en = 1'b1;
        step();
        chk("b3_load_ready", boot_ready, 1);
        chk("b3_load_count0", load_count, 0);
        send(8'h12, 1'b0);
        step();
        chk("b3_stall_ready", boot_ready, 1);
        chk("b3_stall_count", load_count, 1);
        send(8'h34, 1'b0);
        send(8'h56, 1'b1);
        chk("b3_done_ready", boot_ready, 0);
        chk("b3_done_hold", cpu_hold, 1);
        chk("b3_done_count", load_count, 3);
        step();
        chk("b3_run_hold", cpu_hold, 0);
        chk("b3_run_pc", pc, 0);
        chk("b3_run_flash0", flash_data, 8'h12);

        // Fetch sequence.
        pc_inc = 1'b1;
        step();
        chk("fetch_pc1", pc, 1);
        chk("fetch_flash1", flash_data, 8'h34);
        step();
        chk("fetch_pc2", pc, 2);
        chk("fetch_flash2", flash_data, 8'h56);
        pc_inc = 1'b0;
        step();
        chk("fetch_hold_pc", pc, 2);
        chk("fetch_hold_count", load_count, 3);

        // Jump priority over increment, then wrap.
        pc_load = 1'b1; pc_inc = 1'b1; pc_next = 12'hFFF;
        step();
        chk("jump_pc", pc, 12'hFFF);
        pc_load = 1'b0;
        step();
        chk("wrap_pc", pc, 12'h000);
        pc_inc = 1'b0;

        // Overflow load: 4100 bytes offered, no boot_last.
        pulse_reset();
        boot_en = 1'b1; pc_inc = 1'b1; pc_load = 1'b1; pc_next = 12'h005;
        step();
        accepted = 0;
        first_drop = -1;
        for (int i = 0; i < 4100; i++) begin
            if (i == 5) chk("ovf_pc_ignored", pc, 0);
            if (i == 10) begin pc_inc = 1'b0; pc_load = 1'b0; end
            boot_valid = 1'b1;
            boot_data  = 8'(i) ^ 8'hA5;
            if (boot_ready) accepted++;
            else if (first_drop < 0) first_drop = i;
            step();
        end
        boot_valid = 1'b0;
        chk("ovf_accepted", accepted, 4096);
        chk("ovf_first_drop", first_drop, 4096);
        chk("ovf_load_count", load_count, 13'd4096);
        chk("ovf_hold", cpu_hold, 0);
        chk("ovf_pc", pc, 0);
        chk("ovf_mem0", flash_data, 8'hA5);
        pc_load = 1'b1; pc_next = 12'hFFF;
        step();
        pc_load = 1'b0;
        chk("ovf_mem4095", flash_data, 8'h5A);

        // Reset in the middle of a load, then a short reload.
        pulse_reset();
        chk("mid_rst_pc", pc, 0);
        boot_en = 1'b1;
        step();
        for (int i = 0; i < 5; i++) send(8'h10 + 8'(i), 1'b0);
        chk("mid_partial_count", load_count, 5);
        pulse_reset();
        step();
        chk("mid_reload_count0", load_count, 0);
        send(8'hE0, 1'b0);
        send(8'hE1, 1'b1);
        step();
        chk("mid_run_hold", cpu_hold, 0);
        chk("mid_load_count", load_count, 2);
        chk("mid_mem0", flash_data, 8'hE0);
        pc_inc = 1'b1;
        step();
        chk("mid_mem1", flash_data, 8'hE1);
        step();
        chk("mid_mem2", flash_data, 8'h12);
        step();
        chk("mid_mem3", flash_data, 8'h13);
        step();
        chk("mid_mem4", flash_data, 8'h14);
        pc_inc = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
